// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the serial_adder block.
package serial_adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned calc_steps(input int unsigned width, input int unsigned bpc);
        return width / bpc;
    endfunction

    // Counter must hold 0..STEPS-1; a single-step build still keeps a 1-bit counter.
    function automatic int unsigned calc_cnt_w(input int unsigned width, input int unsigned bpc);
        int unsigned n;
        n = $clog2(calc_steps(width, bpc));
        return (n < 32'd1) ? 32'd1 : n;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned bpc);
        return (width >= 32'd1) && (bpc >= 32'd1) && (bpc <= width) && ((width % bpc) == 32'd0);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; the per-step ripple chain is built from these.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: BPC bits per clock, LSB first, start/busy/done handshake.
// Optional subtract mode enabled with macro SERIAL_ADDER_ADD_SUB_EN (adds port sub).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STEPS = calc_steps(WIDTH, BPC);
    localparam int unsigned CNT_W = calc_cnt_w(WIDTH, BPC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 32'd1);

    if (!cfg_ok(WIDTH, BPC)) begin : g_cfg_err
        $error("serial_adder: WIDTH must be >= 1 and a multiple of BPC");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BPC:0]       chain_c_s;
    logic [BPC-1:0]     chain_sum_s;
    logic [WIDTH-1:0]   full_s;

    assign chain_c_s[0] = carry_q;

    for (genvar i = 0; i < BPC; i++) begin : g_cell
        fa_cell u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (chain_c_s[i]),
            .s  (chain_sum_s[i]),
            .co (chain_c_s[i+1])
        );
    end

    // Partial result lives in its own accumulator so sum keeps the previous answer until the last step.
    if (STEPS > 1) begin : g_acc
        logic [WIDTH-BPC-1:0] res_q, res_d;

        assign full_s = {chain_sum_s, res_q};

        // Accumulator next-state: shift this step's bits in from the top while running.
        always_comb begin
            res_d = res_q;
            if (state_q == RUN) begin
                res_d = full_s[WIDTH-1:BPC];
            end else begin
                res_d = res_q;
            end
        end

        // Accumulator register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end
    end else begin : g_no_acc
        assign full_s = chain_sum_s;
    end

    // Next-state and output computation for the IDLE/RUN sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    a_d     = a;
`ifdef SERIAL_ADDER_ADD_SUB_EN
                    // Subtract as a + ~b + 1; cin is ignored in this mode.
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = b;
                        carry_d = cin;
                    end
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = chain_c_s[BPC];
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    sum_d   = full_s;
                    cout_d  = chain_c_s[BPC];
                    ovf_d   = chain_c_s[BPC] ^ chain_c_s[BPC-1];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at BPC = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
`ifdef SERIAL_ADDER_ADD_SUB_EN
    logic       sub_i;
`endif
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] cout_v;
    logic [2:0] ovf_v;
    logic [7:0] sum_v [3];

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADDER_ADD_SUB_EN
        .sub(sub_i),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    serial_adder #(.WIDTH(8), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADDER_ADD_SUB_EN
        .sub(sub_i),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    serial_adder #(.WIDTH(8), .BPC(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADDER_ADD_SUB_EN
        .sub(sub_i),
`endif
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance edges until done, bounded; lat accumulates edges seen since the accepting edge.
    task automatic wait_done(input int sel, inout int lat, inout int bcnt);
        while (!done_v[sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy_v[sel]) bcnt++;
        end
    endtask

    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic [7:0] es, input logic ec, input logic eo, input int elat,
                          input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        a_i = av; b_i = bv; cin_i = cv; start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        a_i = ~av; b_i = ~bv; cin_i = ~cv;
        lat  = 0;
        bcnt = busy_v[sel] ? 1 : 0;
        wait_done(sel, lat, bcnt);
        check_eq({tag, "_lat"},  lat,  elat);
        check_eq({tag, "_busy"}, bcnt, elat);
        check_eq({tag, "_sum"},  sum_v[sel], es);
        check_eq({tag, "_cout"}, cout_v[sel], ec);
        check_eq({tag, "_ovf"},  ovf_v[sel], eo);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, done_v[sel], 1'b0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        logic [8:0] full;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rbe;
        logic       rc;
        logic       rcin;
        logic       rov;
        int         sel;
        int         elat;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        start_v = 3'b000;
        a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
`ifdef SERIAL_ADDER_ADD_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_busy", busy_v[i], 1'b0);
            check_eq("rst_done", done_v[i], 1'b0);
            check_eq("rst_sum",  sum_v[i], 8'h00);
            check_eq("rst_cout", cout_v[i], 1'b0);
            check_eq("rst_ovf",  ovf_v[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8, "zero");
        run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, "wrap");
        run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 8, "povf");
        run_op(0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 8, "novf");

        // Start while busy is ignored; new start in the done cycle is accepted.
        @(negedge clk);
        a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check_eq("hold_sum", sum_v[0], 8'h01);
        lat = 0; bcnt = 1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        a_i = 8'hFF; start_v[0] = 1'b1;
        @(posedge clk); #1;
        lat++;
        start_v[0] = 1'b0;
        check_eq("ign_busy", busy_v[0], 1'b1);
        wait_done(0, lat, bcnt);
        check_eq("ign_lat", lat, 8);
        check_eq("ign_sum", sum_v[0], 8'h46);
        @(negedge clk);
        a_i = 8'hF0; b_i = 8'h20; cin_i = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check_eq("b2b_busy", busy_v[0], 1'b1);
        check_eq("b2b_done", done_v[0], 1'b0);
        check_eq("b2b_hold", sum_v[0], 8'h46);
        lat = 0; bcnt = 1;
        wait_done(0, lat, bcnt);
        check_eq("b2b_lat",  lat, 8);
        check_eq("b2b_sum",  sum_v[0], 8'h10);
        check_eq("b2b_cout", cout_v[0], 1'b1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        a_i = 8'h55; b_i = 8'h11; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", busy_v[0], 1'b0);
        check_eq("mrst_sum",  sum_v[0], 8'h00);
        check_eq("mrst_cout", cout_v[0], 1'b0);
        check_eq("mrst_done", done_v[0], 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_v[0] || busy_v[0]) dcnt++;
        end
        check_eq("mrst_nodone", dcnt, 0);
        run_op(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 8, "post_rst");

        run_op(1, 8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0, 2, "bpc4");
        run_op(2, 8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0, 1, "bpc8");
        run_op(2, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1, "bpc8_ovf");

`ifdef SERIAL_ADDER_ADD_SUB_EN
        sub_i = 1'b1;
        run_op(0, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 8, "sub_neg");
        run_op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 8, "sub_ovf");
        run_op(1, 8'h09, 8'h03, 1'b0, 8'h06, 1'b1, 1'b0, 2, "sub_bpc4");
        sub_i = 1'b0;
`endif

        for (int k = 0; k < 24; k++) begin
            sel  = k % 3;
            elat = (sel == 0) ? 8 : ((sel == 1) ? 2 : 1);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rbe  = rb;
            rcin = rc;
`ifdef SERIAL_ADDER_ADD_SUB_EN
            sub_i = 1'($urandom);
            if (sub_i) begin
                rbe  = ~rb;
                rcin = 1'b1;
            end
`endif
            full = {1'b0, ra} + {1'b0, rbe} + {8'h00, rcin};
            rov  = (ra[7] == rbe[7]) && (full[7] != ra[7]);
            run_op(sel, ra, rb, rc, full[7:0], full[8], rov, elat, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
